multicycle_seq: RTL and testbench

- Multicycle sequencer for the Pac-ARM core. Steps each instruction through FETCH, DECODE, EXEC, MEM and WB states, and drives the shared datapath controls cycle by cycle.
- Arbitrates the single unified memory port between instruction fetch and data access using a req/rdy handshake.
- Latches a sticky fault on an illegal instruction class or a memory timeout.

---
 rtl/multicycle_seq.sv | 148 ++++++++++++++
 tb/tb_multicycle_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_seq.sv
// multicycle_seq: FETCH/DECODE/EXEC/MEM/WB sequencer with unified memory port arbitration and sticky fault
module multicycle_seq #(
    parameter int MEM_WAIT_MAX = 16,
    parameter int WCNT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcodes,
    input  logic [1:0] operation,
    input  logic [3:0] condicion,
    input  logic       zero,
    input  logic       memRdy,
    output logic       irWr,
    output logic       pcWr,
    output logic       selPC,
    output logic       regWr,
    output logic       selAddWr,
    output logic [3:0] opALU,
    output logic       cin,
    output logic [1:0] selDiWr,
    output logic       selOperaB,
    output logic       flagsWr,
    output logic       memReq,
    output logic       memWr,
    output logic       selAddrMem,
    output logic       retire,
    output logic       fault,
    output logic [1:0] faultCode
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, FAULT} state_t;
    localparam logic [WCNT_W-1:0] LIM = WCNT_W'(MEM_WAIT_MAX == 0 ? 0 : MEM_WAIT_MAX - 1);
    state_t            state, nxt;
    logic [1:0]        fault_code, nxt_code;
    logic [WCNT_W-1:0] wait_cnt;
    logic              tmo, taken, is_cmp;
    logic [3:0]        mem_alu;
    assign tmo     = (MEM_WAIT_MAX != 0) && (wait_cnt == LIM);
    assign taken   = (condicion == 4'b0000 && zero) || (condicion == 4'b0001 && !zero) || condicion == 4'b1110;
    assign is_cmp  = opcodes[4:1] == 4'b1010;
    assign mem_alu = opcodes[3] ? 4'b0100 : 4'b0010;
    // state, latched fault code and memory wait counter (cleared on completion or state exit)
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            fault_code <= 2'b00;
            wait_cnt   <= '0;
        end else begin
            state      <= nxt;
            fault_code <= nxt_code;
            wait_cnt   <= (memReq && !memRdy && nxt == state) ? wait_cnt + 1'b1 : '0;
        end
    end
    // next state and datapath controls; everything held low while rst is asserted
    always_comb begin
        nxt        = state;
        nxt_code   = fault_code;
        irWr       = 1'b0;
        pcWr       = 1'b0;
        selPC      = 1'b0;
        regWr      = 1'b0;
        selAddWr   = 1'b0;
        opALU      = 4'b0000;
        cin        = 1'b0;
        selDiWr    = 2'b00;
        selOperaB  = 1'b0;
        flagsWr    = 1'b0;
        memReq     = 1'b0;
        memWr      = 1'b0;
        selAddrMem = 1'b0;
        retire     = 1'b0;
        fault      = 1'b0;
        faultCode  = 2'b00;
        if (!rst) begin
            case (state)
                FETCH: begin
                    memReq = 1'b1;
                    if (memRdy) begin
                        irWr = 1'b1;
                        pcWr = 1'b1;
                        nxt  = DECODE;
                    end else if (tmo) begin
                        nxt      = FAULT;
                        nxt_code = 2'b10;
                    end
                end
                DECODE: begin
                    nxt      = (operation == 2'b11) ? FAULT : EXEC;
                    nxt_code = (operation == 2'b11) ? 2'b01 : fault_code;
                end
                EXEC: begin
                    case (operation)
                        2'b00: begin
                            opALU     = opcodes[4:1];
                            cin       = opcodes[4:1] == 4'b0010;
                            selOperaB = opcodes[5];
                            flagsWr   = 1'b1;
                            retire    = is_cmp;
                            nxt       = is_cmp ? FETCH : WB;
                        end
                        2'b01: begin
                            opALU     = mem_alu;
                            selOperaB = opcodes[5];
                            nxt       = MEM;
                        end
                        2'b10: begin
                            pcWr   = taken;
                            selPC  = taken;
                            retire = opcodes[4];
                            nxt    = opcodes[4] ? FETCH : WB;
                        end
                        default: begin
                            nxt      = FAULT;
                            nxt_code = 2'b01;
                        end
                    endcase
                end
                MEM: begin
                    memReq     = 1'b1;
                    selAddrMem = 1'b1;
                    memWr      = !opcodes[0];
                    opALU      = mem_alu;
                    selOperaB  = opcodes[5];
                    if (memRdy) begin
                        retire = !opcodes[0];
                        nxt    = opcodes[0] ? WB : FETCH;
                    end else if (tmo) begin
                        nxt      = FAULT;
                        nxt_code = 2'b10;
                    end
                end
                WB: begin
                    regWr    = 1'b1;
                    retire   = 1'b1;
                    selAddWr = operation == 2'b10;
                    selDiWr  = (operation == 2'b01) ? 2'b10 :
                               (operation == 2'b10) ? 2'b11 :
                               (opcodes[4:1] == 4'b1101) ? 2'b01 : 2'b00;
                    nxt      = FETCH;
                end
                FAULT: begin
                    fault     = 1'b1;
                    faultCode = fault_code;
                end
                default: nxt = FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_seq.sv
// tb_multicycle_seq: directed checks of the multicycle sequencer controls, cycle by cycle
module tb_multicycle_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcodes = '0;
    logic [1:0] operation = '0;
    logic [3:0] condicion = '0;
    logic       zero = 1'b0;
    logic       memRdy = 1'b1;
    logic       irWr, pcWr, selPC, regWr, selAddWr, cin, selOperaB, flagsWr;
    logic       memReq, memWr, selAddrMem, retire, fault;
    logic [3:0] opALU;
    logic [1:0] selDiWr, faultCode;
    logic [20:0] outs;
    int tests = 0;
    int failed = 0;

    localparam logic [20:0] IR  = 21'h100000;
    localparam logic [20:0] PC  = 21'h080000;
    localparam logic [20:0] SPC = 21'h040000;
    localparam logic [20:0] RW  = 21'h020000;
    localparam logic [20:0] SAW = 21'h010000;
    localparam logic [20:0] CIN = 21'h000800;
    localparam logic [20:0] SOB = 21'h000100;
    localparam logic [20:0] FW  = 21'h000080;
    localparam logic [20:0] MRQ = 21'h000040;
    localparam logic [20:0] MWR = 21'h000020;
    localparam logic [20:0] SAM = 21'h000010;
    localparam logic [20:0] RET = 21'h000008;
    localparam logic [20:0] FLT = 21'h000004;
    localparam logic [20:0] F   = MRQ | IR | PC;

    always #5 clk = ~clk;

    multicycle_seq dut (
        .clk(clk), .rst(rst), .opcodes(opcodes), .operation(operation), .condicion(condicion),
        .zero(zero), .memRdy(memRdy), .irWr(irWr), .pcWr(pcWr), .selPC(selPC), .regWr(regWr),
        .selAddWr(selAddWr), .opALU(opALU), .cin(cin), .selDiWr(selDiWr), .selOperaB(selOperaB),
        .flagsWr(flagsWr), .memReq(memReq), .memWr(memWr), .selAddrMem(selAddrMem),
        .retire(retire), .fault(fault), .faultCode(faultCode)
    );

    assign outs = {irWr, pcWr, selPC, regWr, selAddWr, opALU, cin, selDiWr, selOperaB,
                   flagsWr, memReq, memWr, selAddrMem, retire, fault, faultCode};

    function automatic logic [20:0] alu(input logic [3:0] op);
        return {5'b0, op, 12'b0};
    endfunction
    function automatic logic [20:0] di(input logic [1:0] s);
        return {10'b0, s, 9'b0};
    endfunction
    function automatic logic [20:0] fc(input logic [1:0] c);
        return {19'b0, c};
    endfunction

    task automatic set_instr(input logic [1:0] op, input logic [5:0] opc, input logic [3:0] cond, input logic z);
        operation = op;
        opcodes   = opc;
        condicion = cond;
        zero      = z;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        memRdy = 1'b1;
        set_instr(2'b00, 6'b001000, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 tests++;
            if (outs !== 21'h0) begin failed++; $display("FAIL reset_hold c%0d got=%h exp=%h", i, outs, 21'h0); end
            @(negedge clk);
        end
        rst = 1'b0;
        #1 tests++;
        if (outs !== F) begin failed++; $display("FAIL reset_release got=%h exp=%h", outs, F); end
    endtask

    task automatic test_add;
        logic [20:0] e [4];
        e = '{F, 21'h0, alu(4'b0100) | FW, RW | RET | di(2'b00)};
        set_instr(2'b00, 6'b001000, 4'h0, 1'b0);
        memRdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 tests++;
            if (outs !== e[i]) begin failed++; $display("FAIL add c%0d got=%h exp=%h", i, outs, e[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_dp_variants;
        logic [5:0]  opc [3];
        logic [20:0] ex [3];
        logic [20:0] wb [3];
        logic [20:0] exp_v;
        opc = '{6'b111010, 6'b000100, 6'b101000};
        ex  = '{alu(4'b1101) | SOB | FW, alu(4'b0010) | CIN | FW, alu(4'b0100) | SOB | FW};
        wb  = '{RW | RET | di(2'b01), RW | RET | di(2'b00), RW | RET | di(2'b00)};
        memRdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_instr(2'b00, opc[k], 4'h0, 1'b0);
            for (int i = 0; i < 4; i++) begin
                exp_v = (i == 0) ? F : (i == 1) ? 21'h0 : (i == 2) ? ex[k] : wb[k];
                #1 tests++;
                if (outs !== exp_v) begin failed++; $display("FAIL dp%0d c%0d got=%h exp=%h", k, i, outs, exp_v); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_cmp;
        logic [20:0] e [3];
        e = '{F, 21'h0, alu(4'b1010) | FW | RET};
        set_instr(2'b00, 6'b010100, 4'h0, 1'b0);
        memRdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 tests++;
            if (outs !== e[i]) begin failed++; $display("FAIL cmp c%0d got=%h exp=%h", i, outs, e[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_load_wait;
        logic [20:0] e [8];
        logic        r [8];
        logic [20:0] m;
        m = MRQ | SAM | alu(4'b0100) | SOB;
        e = '{F, 21'h0, alu(4'b0100) | SOB, m, m, m, m, RW | RET | di(2'b10)};
        r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        set_instr(2'b01, 6'b111001, 4'h0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            memRdy = r[i];
            #1 tests++;
            if (outs !== e[i]) begin failed++; $display("FAIL ldr c%0d got=%h exp=%h", i, outs, e[i]); end
            @(negedge clk);
        end
        memRdy = 1'b1;
    endtask

    task automatic test_store;
        logic [20:0] e [4];
        e = '{F, 21'h0, alu(4'b0010), MRQ | MWR | SAM | alu(4'b0010) | RET};
        set_instr(2'b01, 6'b000000, 4'h0, 1'b0);
        memRdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 tests++;
            if (outs !== e[i]) begin failed++; $display("FAIL str c%0d got=%h exp=%h", i, outs, e[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_branch;
        logic [5:0]  opc [4];
        logic [3:0]  cnd [4];
        logic        zz  [4];
        logic [20:0] ex  [4];
        logic [20:0] exp_v;
        logic [20:0] link;
        int n;
        link = RW | RET | SAW | di(2'b11);
        opc = '{6'b010000, 6'b010000, 6'b000000, 6'b000000};
        cnd = '{4'b0000, 4'b0000, 4'b1110, 4'b0001};
        zz  = '{1'b1, 1'b0, 1'b0, 1'b1};
        ex  = '{PC | SPC | RET, RET, PC | SPC, 21'h0};
        memRdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_instr(2'b10, opc[k], cnd[k], zz[k]);
            n = opc[k][4] ? 3 : 4;
            for (int i = 0; i < n; i++) begin
                exp_v = (i == 0) ? F : (i == 1) ? 21'h0 : (i == 2) ? ex[k] : link;
                #1 tests++;
                if (outs !== exp_v) begin failed++; $display("FAIL br%0d c%0d got=%h exp=%h", k, i, outs, exp_v); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_timeout_edge;
        logic [20:0] e [3];
        e = '{21'h0, alu(4'b0100) | FW, RW | RET};
        set_instr(2'b00, 6'b001000, 4'h0, 1'b0);
        memRdy = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1 tests++;
            if (outs !== MRQ) begin failed++; $display("FAIL edge_wait c%0d got=%h exp=%h", i, outs, MRQ); end
            @(negedge clk);
        end
        memRdy = 1'b1;
        #1 tests++;
        if (outs !== F) begin failed++; $display("FAIL edge_done got=%h exp=%h", outs, F); end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1 tests++;
            if (outs !== e[i]) begin failed++; $display("FAIL edge_tail c%0d got=%h exp=%h", i, outs, e[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        logic [20:0] e [4];
        logic        r [4];
        e = '{F, 21'h0, alu(4'b0010), MRQ | MWR | SAM | alu(4'b0010)};
        r = '{1'b1, 1'b1, 1'b1, 1'b0};
        set_instr(2'b01, 6'b000000, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            memRdy = r[i];
            #1 tests++;
            if (outs !== e[i]) begin failed++; $display("FAIL rmid c%0d got=%h exp=%h", i, outs, e[i]); end
            if (i < 3) @(negedge clk);
        end
        rst = 1'b1;
        #1 tests++;
        if (outs !== 21'h0) begin failed++; $display("FAIL rmid_drop got=%h exp=%h", outs, 21'h0); end
        @(negedge clk);
        rst = 1'b0;
        memRdy = 1'b1;
        #1 tests++;
        if (outs !== F) begin failed++; $display("FAIL rmid_fetch got=%h exp=%h", outs, F); end
    endtask

    task automatic test_fault;
        set_instr(2'b11, 6'b000000, 4'h0, 1'b0);
        memRdy = 1'b1;
        #1 tests++;
        if (outs !== F) begin failed++; $display("FAIL ill_fetch got=%h exp=%h", outs, F); end
        @(negedge clk);
        #1 tests++;
        if (outs !== 21'h0) begin failed++; $display("FAIL ill_decode got=%h exp=%h", outs, 21'h0); end
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            memRdy = i[0];
            #1 tests++;
            if (outs !== (FLT | fc(2'b01))) begin failed++; $display("FAIL ill_sticky c%0d got=%h exp=%h", i, outs, FLT | fc(2'b01)); end
            @(negedge clk);
        end
        rst = 1'b1;
        #1 tests++;
        if (outs !== 21'h0) begin failed++; $display("FAIL ill_rst got=%h exp=%h", outs, 21'h0); end
        @(negedge clk);
        rst = 1'b0;
        memRdy = 1'b0;
        set_instr(2'b00, 6'b001000, 4'h0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            #1 tests++;
            if (outs !== MRQ) begin failed++; $display("FAIL to_wait c%0d got=%h exp=%h", i, outs, MRQ); end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            #1 tests++;
            if (outs !== (FLT | fc(2'b10))) begin failed++; $display("FAIL to_fault c%0d got=%h exp=%h", i, outs, FLT | fc(2'b10)); end
            memRdy = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        #1 tests++;
        if (outs !== 21'h0) begin failed++; $display("FAIL to_rst got=%h exp=%h", outs, 21'h0); end
        @(negedge clk);
        rst = 1'b0;
        #1 tests++;
        if (outs !== F) begin failed++; $display("FAIL to_clear got=%h exp=%h", outs, F); end
    endtask

    initial begin
        test_reset;
        test_add;
        test_dp_variants;
        test_cmp;
        test_load_wait;
        test_store;
        test_branch;
        test_timeout_edge;
        test_reset_mid;
        test_fault;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
